aes128_encryptor_iter: RTL and testbench
========================================

Name: aes128_encryptor_iter

Overview:
- Iterative AES-128 (FIPS-197) encryption core: the transmit-side counterpart of the existing decryptor.
- Produces the ciphertext that the decryptor consumes, from the same 128-bit plaintext/key pair.
- Computes one full round per clock, expanding round keys on the fly, with a start/busy/done handshake.
- Sits between the message-loading logic and the link/output register.

Parameters:
- none; AES-128 only, Nr = 10 fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to encrypt; sampled only in IDLE.
- plaintext  input  128  message block, byte 0 = bits [127:120]; sampled on the accepting edge only.
- key  input  128  cipher key, same byte order; sampled on the accepting edge only.
- ciphertext  output  128  result; registered and held until the next completion.
- busy  output  1  high while rounds are in progress.
- done  output  1  single-cycle pulse when the ciphertext is updated.

Behaviour:
- Reset (rst=0, asynchronous) clears everything immediately: FSM=IDLE, round counter=0, state register=0, round-key register=0, ciphertext=0, busy=0, done=0.
- FSM states:
  - IDLE -> RUN on start=1 at edge N.
  - RUN -> IDLE after round 10.
- Accept edge N:
  - state <= plaintext ^ key; rkey <= key; round <= 1; busy <= 1.
  - plaintext and key are not sampled again; changes during RUN are ignored.
- RUN, edges N+1 .. N+10, one round per edge:
  - rkey <= next round key (RotWord, SubWord, Rcon[round]; Rcon = 01,02,04,08,10,20,40,80,1b,36).
  - state <= SubBytes, ShiftRows, MixColumns (omitted when round==10), then AddRoundKey with the new round key.
  - round increments.
- Edge N+10:
  - ciphertext <= final state; done <= 1; busy <= 0; FSM -> IDLE.
  - Latency: done is high in the cycle following edge N+10, i.e. 10 cycles after the accept edge.
- done is high for exactly one cycle. ciphertext keeps its value until the next done.
- start while busy=1 is ignored, with no queueing.
- start=1 in the done cycle is accepted, allowing back-to-back blocks at 1 block per 11 cycles. done deasserts on that edge.
- start held high continuously re-triggers every 11 cycles.
- Reset mid-RUN aborts the operation: no done is produced, and ciphertext returns to 0.
- GF(2^8) xtime reduces with polynomial 0x11b. S-box is a combinational 256-entry lookup: 16 instances for the state, 4 for the key schedule.
- busy and done are never high at the same time.

Optional Feature:
- Macro: AES_LAST_ROUNDKEY_OUT_EN.
- Defined:
  - Adds output port last_roundkey [127:0], reset 0.
  - Loaded with round key 10 on the same edge as ciphertext and held until the next done.
  - Lets the decryptor start its inverse key schedule without re-expanding the key.
- Undefined:
  - Port and register are absent.
  - All other behaviour and timing are identical.

Test Plan:
- FIPS-197 C.1: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, start for 1 cycle -> done pulses 10 cycles after the accept edge; ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; busy high for 10 cycles. With macro: last_roundkey=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App B: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> ciphertext=3925841d02dc09fbdc118597196a0b32. With macro: last_roundkey=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Back-to-back: run App B, then assert start in its done cycle with the C.1 vector -> second done exactly 11 cycles after the first with the C.1 result; first ciphertext held during the gap.
- Ignored start: pulse start with a different vector at cycles 3 and 7 of RUN, and change plaintext/key mid-RUN -> result unchanged; a single done.
- Reset mid-operation: pull rst low at cycle 5 of RUN, asynchronously between edges -> busy, done and ciphertext go to 0 immediately; no done afterwards. After release, a fresh C.1 run gives the correct result.
- Loopback: feed the ciphertext and key into the existing decryptor -> recovered plaintext equals the original for both vectors.

Source files
------------

// File: rtl/aes128_encryptor_iter.sv
// rtl/aes128_encryptor_iter.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
// Optional last round-key output: define AES_LAST_ROUNDKEY_OUT_EN.
module aes128_encryptor_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
`ifdef AES_LAST_ROUNDKEY_OUT_EN
    ,
    output logic [127:0] last_roundkey
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [0:0]   fsm;
    logic [3:0]   round;
    logic [127:0] state;
    logic [127:0] rkey;

    logic [31:0]  w3, temp, k0, k1, k2, k3;
    logic [127:0] nkey;
    logic [127:0] sub_shift;
    logic [127:0] mixed;
    logic [127:0] next_state;

    // Next round key: only the last word of the current key feeds the S-boxes.
    always_comb begin
        w3   = rkey[31:0];
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon(round), 24'h000000};
        k0   = rkey[127:96] ^ temp;
        k1   = rkey[95:64]  ^ k0;
        k2   = rkey[63:32]  ^ k1;
        k3   = w3           ^ k2;
        nkey = {k0, k1, k2, k3};
    end

    // Byte i sits at bits [127-8i -: 8], row i%4, column i/4; ShiftRows rotates row r left by r.
    always_comb begin
        sub_shift = '0;
        mixed     = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127-8*(r+4*c) -: 8] = sbox(state[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_col(sub_shift[127-32*c -: 32]);
        end
        next_state = ((round == 4'd10) ? sub_shift : mixed) ^ nkey;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm        <= ST_IDLE;
            round      <= 4'd0;
            state      <= '0;
            rkey       <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef AES_LAST_ROUNDKEY_OUT_EN
            last_roundkey <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        state <= plaintext ^ key;
                        rkey  <= key;
                        round <= 4'd1;
                        busy  <= 1'b1;
                        fsm   <= ST_RUN;
                    end
                end
                default: begin
                    rkey  <= nkey;
                    state <= next_state;
                    if (round == 4'd10) begin
                        ciphertext <= next_state;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        round      <= 4'd0;
                        fsm        <= ST_IDLE;
`ifdef AES_LAST_ROUNDKEY_OUT_EN
                        last_roundkey <= nkey;
`endif
                    end else begin
                        round <= round + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encryptor_iter.sv
// tb/tb_aes128_encryptor_iter.sv - scoreboard bench for aes128_encryptor_iter with FIPS-197 vectors
module tb_aes128_encryptor_iter;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_LRK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_LRK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct packed {
        logic [127:0] ct;
        logic [127:0] lrk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;
`ifdef AES_LAST_ROUNDKEY_OUT_EN
    logic [127:0] last_roundkey;
`endif

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    aes128_encryptor_iter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done)
`ifdef AES_LAST_ROUNDKEY_OUT_EN
        ,
        .last_roundkey (last_roundkey)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            exp_t e;
            chk("busy_during_done", {127'd0, busy}, 128'd0);
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done with ciphertext %h expected no done", ciphertext);
            end else begin
                e = q.pop_front();
                chk("ciphertext", ciphertext, e.ct);
`ifdef AES_LAST_ROUNDKEY_OUT_EN
                chk("last_roundkey", last_roundkey, e.lrk);
`endif
            end
        end
    end

    task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                         input logic [127:0] ct, input logic [127:0] lrk);
        exp_t e;
        e.ct  = ct;
        e.lrk = lrk;
        q.push_back(e);
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accept edge until done; checks ciphertext holds meanwhile.
    task automatic wait_done(output int n, output int nb);
        logic [127:0] held;
        held = ciphertext;
        n    = 0;
        nb   = busy ? 1 : 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) nb++;
            chk("ciphertext_held", ciphertext, held);
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    initial begin
        int n, nb;
        rst       = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ciphertext", ciphertext, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_done", {127'd0, done}, 128'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // FIPS-197 C.1
        issue(C1_PT, C1_KEY, C1_CT, C1_LRK);
        wait_done(n, nb);
        chk("c1_latency", 128'(n), 128'd10);
        chk("c1_busy_cycles", 128'(nb), 128'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("done_single_pulse", {127'd0, done}, 128'd0);

        // FIPS-197 Appendix B, then C.1 issued in its done cycle
        issue(B_PT, B_KEY, B_CT, B_LRK);
        wait_done(n, nb);
        chk("appb_latency", 128'(n), 128'd10);
        issue(C1_PT, C1_KEY, C1_CT, C1_LRK);
        chk("b2b_done_dropped", {127'd0, done}, 128'd0);
        wait_done(n, nb);
        chk("b2b_gap", 128'(n + 1), 128'd11);
        repeat (3) @(posedge clk);
        #1;

        // Ignored start pulses and input changes during RUN
        issue(B_PT, B_KEY, B_CT, B_LRK);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (done) break;
            if (n == 2 || n == 6) begin
                start     = 1'b1;
                plaintext = C1_PT;
                key       = C1_KEY;
            end
            if (n == 4) begin
                plaintext = ~B_PT;
                key       = ~B_KEY;
            end
        end
        chk("ignored_start_latency", 128'(n), 128'd10);
        repeat (15) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a run
        plaintext = C1_PT;
        key       = C1_KEY;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_ciphertext", ciphertext, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_abort_busy", {127'd0, busy}, 128'd0);

        issue(C1_PT, C1_KEY, C1_CT, C1_LRK);
        wait_done(n, nb);
        chk("fresh_c1_latency", 128'(n), 128'd10);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
